// File: rtl/led_ctrl_pkg.sv
// Shared mode encoding and sizing helpers for the LED mode controller.
// Imported by the RTL and by the bench so both agree on the mode sequence.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_XOR     = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_XOR:     return MODE_BLINK;
      MODE_BLINK:   return MODE_BREATHE;
      MODE_BREATHE: return MODE_OFF;
      default:      return MODE_XOR;
    endcase
  endfunction

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus debounce for one raw switch; a change held steady
// appears on stable DEBOUNCE_CYCLES+2 cycles later, any bounce restarts the count.
module switch_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16000
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic stable
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync   <= 2'b00;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[0], raw};
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;

endmodule

// File: rtl/led_mode_ctrl.sv
// Debounces both switches, steps the mode on each two-switch chord press and
// drives the registered LED from XOR, blink, PWM breathing or off.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int BLINK_HALF      = 8000000,
  parameter int PWM_BITS        = 8,
  parameter int BREATH_STEP     = 31250
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW1,
  input  logic       SW2,
  output logic       LED,
  output logic       USBPU,
  output logic [1:0] MODE
);

  localparam int BW = cnt_width(BLINK_HALF);
  localparam int SW = cnt_width(BREATH_STEP);
  localparam logic [BW-1:0]       BLINK_LAST    = BW'(BLINK_HALF - 1);
  localparam logic [SW-1:0]       STEP_LAST     = SW'(BREATH_STEP - 1);
  localparam logic [PWM_BITS-1:0] DUTY_ONE      = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_NEAR_TOP = ~DUTY_ONE;

  logic                w_stable1, w_stable2, w_chord, w_rise;
  logic                r_chord_q;
  mode_t               r_mode, w_mode_nxt;
  logic [BW-1:0]       r_blink_cnt;
  logic                r_phase, w_phase_nxt;
  logic [PWM_BITS-1:0] r_pwm_cnt, r_duty;
  logic [SW-1:0]       r_step_cnt;
  logic                r_dir_down;
  logic                r_led, w_led_nxt;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .CLK(CLK), .RST(RST), .raw(SW1), .stable(w_stable1)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
    .CLK(CLK), .RST(RST), .raw(SW2), .stable(w_stable2)
  );

  assign w_chord = w_stable1 & w_stable2;
  assign w_rise  = w_chord & ~r_chord_q;

  // LED in BLINK follows the post-edge phase so the first rise lands
  // exactly BLINK_HALF cycles after MODE changes.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_phase_nxt = r_phase;
    w_led_nxt   = 1'b0;
    if (w_rise) w_mode_nxt = next_mode(r_mode);
    if (r_blink_cnt == BLINK_LAST) w_phase_nxt = ~r_phase;
    case (r_mode)
      MODE_XOR:     w_led_nxt = w_stable1 ^ w_stable2;
      MODE_BLINK:   w_led_nxt = w_phase_nxt;
      MODE_BREATHE: w_led_nxt = (r_pwm_cnt < r_duty);
      default:      w_led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_chord_q   <= 1'b0;
      r_mode      <= MODE_XOR;
      r_led       <= 1'b0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_pwm_cnt   <= '0;
      r_duty      <= '0;
      r_step_cnt  <= '0;
      r_dir_down  <= 1'b0;
    end else begin
      r_chord_q <= w_chord;
      r_mode    <= w_mode_nxt;
      r_led     <= w_led_nxt;
      if (w_rise) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
        r_pwm_cnt   <= '0;
        r_duty      <= '0;
        r_step_cnt  <= '0;
        r_dir_down  <= 1'b0;
      end else begin
        if (r_mode == MODE_BLINK) begin
          r_phase     <= w_phase_nxt;
          r_blink_cnt <= (r_blink_cnt == BLINK_LAST) ? '0 : r_blink_cnt + 1'b1;
        end
        if (r_mode == MODE_BREATHE) begin
          r_pwm_cnt <= r_pwm_cnt + 1'b1;
          if (r_step_cnt == STEP_LAST) begin
            r_step_cnt <= '0;
            // Direction turns at the extremes so duty traces a triangle.
            if (!r_dir_down) begin
              r_duty <= r_duty + 1'b1;
              if (r_duty == DUTY_NEAR_TOP) r_dir_down <= 1'b1;
            end else begin
              r_duty <= r_duty - 1'b1;
              if (r_duty == DUTY_ONE) r_dir_down <= 1'b0;
            end
          end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign LED   = r_led;
  assign USBPU = 1'b0;
  assign MODE  = r_mode;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: directed scenarios plus random switch activity,
// all compared against a behavioural model of the switch/mode/LED rules.
module tb_led_mode_ctrl;
  import led_ctrl_pkg::*;

  localparam int DEB  = 4;
  localparam int BH   = 10;
  localparam int PWMB = 3;
  localparam int BS   = 2;
  localparam logic [31:0] WMASK = (32'd1 << DEB) - 32'd1;

  logic       CLK, RST, SW1, SW2;
  logic       LED, USBPU;
  logic [1:0] MODE;

  int checks = 0;
  int errors = 0;

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .BLINK_HALF(BH), .PWM_BITS(PWMB), .BREATH_STEP(BS)
  ) dut (
    .CLK(CLK), .RST(RST), .SW1(SW1), .SW2(SW2),
    .LED(LED), .USBPU(USBPU), .MODE(MODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model state: raw-sample and synced-sample histories per switch, newest in bit 0.
  logic [31:0] m_h[2];
  logic [31:0] m_g[2];
  int          m_hn[2];
  int          m_gn[2];
  bit          m_st[2];
  bit          m_chq;
  int          m_mode;
  int          m_age;
  bit          m_led;

  function automatic int tri_duty(input int n);
    int p;
    int r;
    p = (1 << PWMB) - 1;
    r = n % (2 * p);
    return (r <= p) ? r : 2 * p - r;
  endfunction

  task automatic model_step();
    bit raw[2];
    bit g;
    bit led_n;
    bit adv;
    raw[0] = SW1;
    raw[1] = SW2;
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        m_h[i] = '0; m_g[i] = '0; m_hn[i] = 0; m_gn[i] = 0; m_st[i] = 1'b0;
      end
      m_chq = 1'b0; m_mode = 0; m_age = 0; m_led = 1'b0;
      return;
    end
    case (m_mode)
      0:       led_n = m_st[0] ^ m_st[1];
      1:       led_n = (((m_age + 1) / BH) % 2) == 1;
      2:       led_n = (m_age % (1 << PWMB)) < tri_duty(m_age / BS);
      default: led_n = 1'b0;
    endcase
    adv   = m_st[0] && m_st[1] && !m_chq;
    m_chq = m_st[0] && m_st[1];
    for (int i = 0; i < 2; i++) begin
      g = (m_hn[i] >= 2) ? m_h[i][1] : 1'b0;
      m_h[i] = {m_h[i][30:0], raw[i]};
      if (m_hn[i] < 64) m_hn[i]++;
      m_g[i] = {m_g[i][30:0], g};
      if (m_gn[i] < 64) m_gn[i]++;
      // Accept a new level once the last DEB synced samples all disagree with it.
      if (m_gn[i] >= DEB && (m_g[i] & WMASK) == (m_st[i] ? 32'd0 : WMASK))
        m_st[i] = !m_st[i];
    end
    if (adv) begin
      m_mode = (m_mode + 1) % 4;
      m_age  = 0;
    end else begin
      m_age++;
    end
    m_led = led_n;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; SW1 = 1'b0; SW2 = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; SW1 = 1'b1; SW2 = 1'b0;
    repeat (3) tick();
    checks++;
    if (MODE !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", MODE); end
    checks++;
    if (LED !== 1'b0) begin errors++; $display("FAIL reset_led: got %b expected 0", LED); end
    checks++;
    if (USBPU !== 1'b0) begin errors++; $display("FAIL reset_usbpu: got %b expected 0", USBPU); end
    RST = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (LED !== (k == 7)) begin
        errors++; $display("FAIL reset_release_led k=%0d: got %b expected %b", k, LED, k == 7);
      end
    end
  endtask

  task automatic test_debounce();
    int hold;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      SW1 = (i % 2 == 0);
      repeat (2) begin
        tick();
        checks++;
        if (LED !== 1'b0) begin errors++; $display("FAIL bounce_led: got %b expected 0", LED); end
      end
    end
    SW1 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (LED !== (k == 7)) begin
        errors++; $display("FAIL debounce_latency k=%0d: got %b expected %b", k, LED, k == 7);
      end
    end
    hold = 0;
    for (int c = 0; c < 300; c++) begin
      if (hold == 0) begin
        SW1  = $urandom_range(0, 1);
        hold = $urandom_range(1, 2 * DEB + 2);
      end
      hold--;
      tick();
      checks++;
      if (LED !== m_led) begin
        errors++; $display("FAIL debounce_random c=%0d: got %b expected %b", c, LED, m_led);
      end
    end
  endtask

  task automatic test_chord();
    int exp_mode;
    int lag;
    do_reset();
    SW1 = 1'b1; SW2 = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if (MODE !== 2'(m_mode)) begin
        errors++; $display("FAIL chord_hold c=%0d: got %0d expected %0d", c, MODE, m_mode);
      end
    end
    checks++;
    if (MODE !== 2'd1) begin errors++; $display("FAIL chord_first: got %0d expected 1", MODE); end
    exp_mode = 1;
    for (int p = 0; p < 3; p++) begin
      SW1 = 1'b0; SW2 = 1'b0;
      repeat ($urandom_range(8, 14)) tick();
      lag = $urandom_range(0, 3);
      SW1 = 1'b1;
      repeat (lag) tick();
      SW2 = 1'b1;
      for (int c = 0; c < 20; c++) begin
        tick();
        checks++;
        if (MODE !== 2'(m_mode) || LED !== m_led) begin
          errors++;
          $display("FAIL chord_press p=%0d c=%0d: got mode %0d led %b expected mode %0d led %b",
                   p, c, MODE, LED, m_mode, m_led);
        end
      end
      exp_mode = (exp_mode + 1) % 4;
      checks++;
      if (MODE !== 2'(exp_mode)) begin
        errors++; $display("FAIL chord_step p=%0d: got %0d expected %0d", p, MODE, exp_mode);
      end
    end
  endtask

  task automatic test_blink();
    int n;
    int highs;
    do_reset();
    SW1 = 1'b1; SW2 = 1'b1;
    n = 0;
    while (MODE !== 2'd1 && n < 20) begin tick(); n++; end
    checks++;
    if (n != DEB + 3) begin errors++; $display("FAIL blink_entry: got %0d cycles expected %0d", n, DEB + 3); end
    highs = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k > 10) highs += int'(LED === 1'b1);
      checks++;
      if (LED !== (((k / BH) % 2) == 1) || MODE !== 2'd1) begin
        errors++;
        $display("FAIL blink_led k=%0d: got led %b mode %0d expected led %b mode 1",
                 k, LED, MODE, ((k / BH) % 2) == 1);
      end
    end
    checks++;
    if (highs != 20) begin errors++; $display("FAIL blink_duty: got %0d high expected 20", highs); end
  endtask

  task automatic test_breathe();
    int  n;
    bit  exp;
    SW1 = 1'b0; SW2 = 1'b0;
    repeat (10) tick();
    SW1 = 1'b1; SW2 = 1'b1;
    n = 0;
    while (MODE !== 2'd2 && n < 20) begin tick(); n++; end
    checks++;
    if (n != DEB + 3) begin errors++; $display("FAIL breathe_entry: got %0d cycles expected %0d", n, DEB + 3); end
    for (int k = 1; k <= 70; k++) begin
      tick();
      exp = ((k - 1) % (1 << PWMB)) < tri_duty((k - 1) / BS);
      checks++;
      if (LED !== exp || MODE !== 2'd2) begin
        errors++;
        $display("FAIL breathe_led k=%0d: got led %b mode %0d expected led %b mode 2", k, LED, MODE, exp);
      end
    end
  endtask

  task automatic test_reset_mid_blink();
    int n;
    do_reset();
    SW1 = 1'b1; SW2 = 1'b1;
    n = 0;
    while (!(MODE === 2'd1 && LED === 1'b1) && n < 40) begin tick(); n++; end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL midblink_wait: got timeout expected led high in blink"); end
    RST = 1'b1;
    tick();
    checks++;
    if (LED !== 1'b0 || MODE !== 2'd0) begin
      errors++; $display("FAIL midblink_reset: got led %b mode %0d expected led 0 mode 0", LED, MODE);
    end
    RST = 1'b0; SW1 = 1'b0; SW2 = 1'b0;
  endtask

  task automatic test_random_mix();
    int h1;
    int h2;
    do_reset();
    h1 = 0; h2 = 0;
    for (int c = 0; c < 1500; c++) begin
      if (h1 == 0) begin SW1 = $urandom_range(0, 1); h1 = $urandom_range(1, 14); end
      if (h2 == 0) begin SW2 = $urandom_range(0, 1); h2 = $urandom_range(1, 14); end
      h1--; h2--;
      tick();
      checks++;
      if (LED !== m_led || MODE !== 2'(m_mode)) begin
        errors++;
        $display("FAIL random_mix c=%0d: got led %b mode %0d expected led %b mode %0d",
                 c, LED, MODE, m_led, m_mode);
      end
    end
  endtask

  initial begin
    RST = 1'b1; SW1 = 1'b0; SW2 = 1'b0;
    test_reset();
    test_debounce();
    test_chord();
    test_blink();
    test_breathe();
    test_reset_mid_blink();
    test_random_mix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
